ser2par_sample: RTL
===================

Name: ser2par_sample

Overview:
Bit-serial to parallel receiver for signed N-bit two's-complement samples (e.g. from a serial ADC), MSB first. It sits directly upstream of the sign-extension stage: o_data drives that stage's i_x, which widens the sample to M bits. Provides a valid/ready output handshake, frame resynchronisation and overrun reporting.

Parameters:
N, 12, sample width in bits (N >= 2); must equal the downstream sign extender's N.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_sen  in  1  serial bit enable; i_sdata/i_sframe sampled only when 1
i_sdata  in  1  serial data bit, MSB of sample first
i_sframe  in  1  frame marker; qualified by i_sen, marks the MSB bit
o_data  out  N  assembled sample, stable while o_valid=1
o_valid  out  1  o_data holds an unconsumed sample
i_ready  in  1  downstream accepts o_data
o_ovr  out  1  one-cycle pulse: completed sample dropped (output busy)
o_resync  out  1  one-cycle pulse: frame marker arrived mid-sample, partial discarded
o_perr  out  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, bit counter 0, shift register 0, o_data=0, o_valid=0, o_ovr=0, o_resync=0, o_perr=0. Reset mid-sample discards the partial word; reset with o_valid=1 discards the held word.
- States: IDLE, SHIFT.
- IDLE: i_sen & i_sframe -> shift in i_sdata as MSB, count=1, go SHIFT. i_sen & !i_sframe -> bit ignored.
- SHIFT: each i_sen=1 cycle shifts i_sdata in at LSB side, count+1. i_sen=0 cycles are gaps: nothing changes, no timeout.
- Completion: the edge sampling the Nth bit returns to IDLE and, if the output register is free, loads o_data and sets o_valid on that same edge (latency 0 cycles from last-bit edge).
- Output register free = o_valid=0, or o_valid & i_ready on the same edge (simultaneous accept and load: o_data takes the new word, o_valid stays 1).
- Overrun: completion while o_valid=1 & i_ready=0 -> new word dropped, o_data unchanged, o_ovr=1 for one cycle.
- Handshake: transfer on edge with o_valid & i_ready; o_valid clears next edge unless reloaded. o_valid never drops without a transfer. i_ready while o_valid=0 has no effect.
- Resync: i_sen & i_sframe while in SHIFT with count in 1..N-1 -> partial discarded, this bit taken as new MSB, count=1, o_resync pulse. i_sframe on the Nth bit position of SHIFT is the Nth data bit with a framing error: word discarded, restart as above, o_resync pulse.
- Pulses o_ovr/o_resync/o_perr are registered, high exactly one cycle per event.
- No arithmetic on data; bit order preserved: first received bit -> o_data[N-1].

Optional Feature:
SER2PAR_PARITY_EN: when defined, each frame carries N data bits followed by one even-parity bit (XOR of N data bits plus parity bit = 0). Completion moves to the parity-bit edge; mismatch drops the word, pulses o_perr, and does not touch o_valid/o_data. Resync rules extend to count N. Without the macro: frame is N bits, o_perr tied to 0, port retained.

Decomposition:
- Package ser2par_pkg: state typedef (IDLE, SHIFT), localparam CNT_W = $clog2(N+2), frame length constant selected by the macro.
- One natural sub-module: ser2par_bitcnt (loadable saturating bit counter with clear/load-1, enable, terminal-count flag); the FSM, shift register and output register stay in the top.

Test Plan:
- Reset: assert i_rst_n=0 mid-SHIFT after 5 bits with o_valid=1 -> all outputs 0 immediately; next full frame 12'h5A3 arrives intact.
- Basic: N=12, frame 12'h800 (-2048), i_ready=1 -> o_valid high one cycle at last-bit edge, o_data=12'h800; downstream extender yields 32'hFFFFF800. Repeat 12'h7FF -> 32'h000007FF.
- Gaps/backpressure: frame 12'hABC with i_sen toggling 1/0, i_ready=0 for 10 cycles -> o_data=12'hABC held, o_valid stays 1 until ready edge, then drops.
- Overrun: hold i_ready=0, send 12'h111 then 12'h222 -> o_data stays 12'h111, one o_ovr pulse at 12'h222 last bit; simultaneous accept+complete case -> o_data=12'h222, o_valid continuous.
- Resync: i_sframe on bit 7 of a frame then full 12'h0F0 -> one o_resync pulse, only 12'h0F0 delivered.
- With SER2PAR_PARITY_EN: 12'h001 + parity 1 -> delivered; 12'h001 + parity 0 -> o_perr pulse, o_valid stays 0.

Source files
------------

// File: rtl/ser2par_pkg.sv
// Shared types and sizing helpers for the ser2par_sample serial receiver.
// SER2PAR_PARITY_EN adds a trailing even-parity bit to every frame.
package ser2par_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned SER2PAR_N = 12;

  // Bits per frame: N data bits, plus one parity bit when enabled.
  function automatic int unsigned frame_len_f(input int unsigned n);
`ifdef SER2PAR_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned n);
    return unsigned'($clog2(n + 2));
  endfunction

  localparam int unsigned CNT_W     = cnt_w_f(SER2PAR_N);
  localparam int unsigned FRAME_LEN = frame_len_f(SER2PAR_N);

endpackage

// File: rtl/ser2par_sample_if.sv
// Serial-in / sample-out bundle of ser2par_sample; slave is the receiver side.
interface ser2par_sample_if #(
  parameter int unsigned N = ser2par_pkg::SER2PAR_N
);
  logic         i_sen;
  logic         i_sdata;
  logic         i_sframe;
  logic         i_ready;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic         o_ovr;
  logic         o_resync;
  logic         o_perr;

  modport master (
    output i_sen, i_sdata, i_sframe, i_ready,
    input  o_data, o_valid, o_ovr, o_resync, o_perr
  );

  modport slave (
    input  i_sen, i_sdata, i_sframe, i_ready,
    output o_data, o_valid, o_ovr, o_resync, o_perr
  );
endinterface

// File: rtl/ser2par_bitcnt.sv
// Bit counter for the serial receiver: clear, load-to-1, saturating increment
// and a combinational flag when the count sits at the terminal value.
module ser2par_bitcnt #(
  parameter int unsigned W  = 4,
  parameter int unsigned TC = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load1_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over load, load wins over increment; hold once at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = W'(1);
    end else if (en_i && (cnt_q != W'(TC))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == W'(TC));

endmodule

// File: rtl/ser2par_sample.sv
// MSB-first bit-serial to parallel receiver for signed N-bit samples with
// valid/ready output, frame resync and overrun pulses. SER2PAR_PARITY_EN
// enables the trailing even-parity bit check and the o_perr pulse.
module ser2par_sample
  import ser2par_pkg::*;
#(
  parameter int unsigned N = SER2PAR_N
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ser2par_sample_if.slave  bus
);

  localparam int unsigned CW   = cnt_w_f(N);
  localparam int unsigned FLEN = frame_len_f(N);

  state_e       state_q, state_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         resync_q, resync_d;
  logic [N-1:0] shift_nx;
  logic [N-1:0] word;
  logic         par_ok;
  logic         cnt_clr, cnt_load1, cnt_en, cnt_tc;
`ifdef SER2PAR_PARITY_EN
  logic         par_q, par_d;
  logic         perr_q, perr_d;
`endif

  ser2par_bitcnt #(
    .W  (CW),
    .TC (FLEN - 1)
  ) u_bitcnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .en_i    (cnt_en),
    .tc_c_o  (cnt_tc)
  );

  // Shift left, new bit at LSB; the oldest bit falls off the top.
  assign shift_nx = N'({shift_q, bus.i_sdata});

`ifdef SER2PAR_PARITY_EN
  // Last frame bit is parity: data is already complete in the shifter.
  assign word   = shift_q;
  assign par_ok = ~(par_q ^ bus.i_sdata);
`else
  assign word   = shift_nx;
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~bus.i_ready;
    ovr_d     = 1'b0;
    resync_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_en    = 1'b0;
`ifdef SER2PAR_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_sen && bus.i_sframe) begin
          state_d   = SHIFT;
          shift_d   = N'(bus.i_sdata);
          cnt_load1 = 1'b1;
`ifdef SER2PAR_PARITY_EN
          par_d     = bus.i_sdata;
`endif
        end
      end
      SHIFT: begin
        if (bus.i_sen) begin
          if (bus.i_sframe) begin
            // Marker inside a frame (even on its last bit): restart on this bit.
            shift_d   = N'(bus.i_sdata);
            cnt_load1 = 1'b1;
            resync_d  = 1'b1;
`ifdef SER2PAR_PARITY_EN
            par_d     = bus.i_sdata;
`endif
          end else if (cnt_tc) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            if (!par_ok) begin
`ifdef SER2PAR_PARITY_EN
              perr_d = 1'b1;
`endif
            end else if (!valid_q || bus.i_ready) begin
              data_d  = word;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            shift_d = shift_nx;
            cnt_en  = 1'b1;
`ifdef SER2PAR_PARITY_EN
            par_d   = par_q ^ bus.i_sdata;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      resync_q <= 1'b0;
`ifdef SER2PAR_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      resync_q <= resync_d;
`ifdef SER2PAR_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_ovr    = ovr_q;
  assign bus.o_resync = resync_q;
`ifdef SER2PAR_PARITY_EN
  assign bus.o_perr   = perr_q;
`else
  assign bus.o_perr   = 1'b0;
`endif

endmodule
